// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: operation codes, data width and op-class helpers shared
// by the HI/LO unit and its arithmetic datapath.
// Optional build macro: MDU_MADD_EN (enables the multiply-accumulate family).
package mult_div_unit_pkg;

  localparam int MduWidth = 32;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  function automatic logic isDivOp(mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic isMaddOp(mdu_op_e o);
    return (o == MDU_MADD) || (o == MDU_MADDU) || (o == MDU_MSUB) || (o == MDU_MSUBU);
  endfunction

  function automatic logic isSubOp(mdu_op_e o);
    return (o == MDU_MSUB) || (o == MDU_MSUBU);
  endfunction

  // Signed flavours of the multiplier need sign-extended operands.
  function automatic logic isSignedMul(mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_MADD) || (o == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// mult_div_unit_arith: purely combinational datapath. Turns the latched
// operands and op into the 64-bit {hi,lo} result (raw product for the
// accumulate ops) and flags a zero divisor.
module mult_div_unit_arith
  import mult_div_unit_pkg::*;
(
  input  mdu_op_e               op_i,
  input  logic [MduWidth-1:0]   a_i,
  input  logic [MduWidth-1:0]   b_i,
  output logic [2*MduWidth-1:0] result_o,
  output logic                  divZero_o
);

  logic [2*MduWidth-1:0]      extA;
  logic [2*MduWidth-1:0]      extB;
  logic signed [MduWidth-1:0] sQuot;
  logic signed [MduWidth-1:0] sRem;
  logic [MduWidth-1:0]        uQuot;
  logic [MduWidth-1:0]        uRem;
  logic                       divOverflow;

  assign divZero_o   = (b_i == '0);
  assign divOverflow = (a_i == {1'b1, {(MduWidth-1){1'b0}}}) && (b_i == '1);

  // Extend operands to 64 bits so one truncated multiply serves both signednesses.
  always_comb begin
    if (isSignedMul(op_i)) begin
      extA = {{MduWidth{a_i[MduWidth-1]}}, a_i};
      extB = {{MduWidth{b_i[MduWidth-1]}}, b_i};
    end else begin
      extA = {{MduWidth{1'b0}}, a_i};
      extB = {{MduWidth{1'b0}}, b_i};
    end
  end

  // Divide only when the divisor is usable; the one signed overflow case is handled separately.
  always_comb begin
    sQuot = '0;
    sRem  = '0;
    uQuot = '0;
    uRem  = '0;
    if (!divZero_o) begin
      uQuot = a_i / b_i;
      uRem  = a_i % b_i;
      if (!divOverflow) begin
        sQuot = $signed(a_i) / $signed(b_i);
        sRem  = $signed(a_i) % $signed(b_i);
      end
    end
  end

  // Select the result for the op class; most-negative / -1 yields lo=a, hi=0.
  always_comb begin
    result_o = '0;
    case (op_i)
      MDU_DIV:  result_o = divOverflow ? {{MduWidth{1'b0}}, a_i} : {sRem, sQuot};
      MDU_DIVU: result_o = {uRem, uQuot};
      default:  result_o = extA * extB;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage MIPS HI/LO unit. Accepts an op when start is high,
// kill is low and no long op is in flight; MTHI/MTLO write in one cycle,
// multiplies and divides hold busy for a fixed latency and then commit.
// Optional build macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate into HI/LO).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                kill,
  input  logic [3:0]          op,
  input  logic [MduWidth-1:0] a,
  input  logic [MduWidth-1:0] b,
  output logic                busy,
  output logic [MduWidth-1:0] hi,
  output logic [MduWidth-1:0] lo
);

  localparam int MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CntW   = $clog2(MaxLat + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_LAT);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_LAT);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  logic [MduWidth-1:0]   hi_q, hi_d;
  logic [MduWidth-1:0]   lo_q, lo_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  mdu_op_e               opLat_q, opLat_d;
  logic [MduWidth-1:0]   aLat_q, aLat_d;
  logic [MduWidth-1:0]   bLat_q, bLat_d;

  mdu_op_e               opIn;
  logic                  accept;
  logic [2*MduWidth-1:0] arithResult;
  logic                  divByZero;

  assign opIn   = mdu_op_e'(op);
  assign busy   = (cnt_q != '0);
  assign accept = start && !kill && !busy;
  assign hi     = hi_q;
  assign lo     = lo_q;

  mult_div_unit_arith u_arith (
    .op_i      (opLat_q),
    .a_i       (aLat_q),
    .b_i       (bLat_q),
    .result_o  (arithResult),
    .divZero_o (divByZero)
  );

  // Next state: count down and commit an in-flight op, otherwise accept a new one.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    opLat_d = opLat_q;
    aLat_d  = aLat_q;
    bLat_d  = bLat_q;
    if (busy) begin
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        if (isDivOp(opLat_q)) begin
          if (!divByZero) begin
            {hi_d, lo_d} = arithResult;
          end
        end
`ifdef MDU_MADD_EN
        else if (isMaddOp(opLat_q)) begin
          if (isSubOp(opLat_q)) begin
            {hi_d, lo_d} = {hi_q, lo_q} - arithResult;
          end else begin
            {hi_d, lo_d} = {hi_q, lo_q} + arithResult;
          end
        end
`endif
        else begin
          {hi_d, lo_d} = arithResult;
        end
      end
    end else if (accept) begin
      case (opIn)
        MDU_MTHI: hi_d = a;
        MDU_MTLO: lo_d = a;
        MDU_MULT, MDU_MULTU: begin
          cnt_d   = MultLoad;
          opLat_d = opIn;
          aLat_d  = a;
          bLat_d  = b;
        end
        MDU_DIV, MDU_DIVU: begin
          cnt_d   = DivLoad;
          opLat_d = opIn;
          aLat_d  = a;
          bLat_d  = b;
        end
`ifdef MDU_MADD_EN
        MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
          cnt_d   = MultLoad;
          opLat_d = opIn;
          aLat_d  = a;
          bLat_d  = b;
        end
`endif
        default: ;
      endcase
    end
  end

  // State registers; reset aborts any op in flight and clears HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      opLat_q <= MDU_NOP;
      aLat_q  <= '0;
      bLat_q  <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      opLat_q <= opLat_d;
      aLat_q  <= aLat_d;
      bLat_q  <= bLat_d;
    end
  end

endmodule
